gem_cluster_es_lookup: RTL and testbench
========================================

Name: gem_cluster_es_lookup

Overview:
- Per-BX sequencer upstream and downstream of the dual-port GEM-pad-to-CSC-eighth-strip ROM.
- Latches up to MXCLST GEM pad clusters on a start strobe and issues one cluster per clock to the ROM: first pad on port 0, last pad on port 1.
- Captures the 1-clock-latency ROM data and emits an ordered (es_lo, es_hi) eighth-strip range per cluster for the GEM-CSC matching logic.

Parameters:
MXCLST, 8, clusters per BX
MXCLSTB, 3, cluster index width
MXADRB, 8, ROM address (pad) width
MXDATB, 10, ROM data (eighth-strip) width
MXCNTB, 3, cluster size field width (size-1)
ROMLENGTH, 192, valid pads 0..ROMLENGTH-1

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle strobe, cluster inputs valid this cycle
clst_vpf  in  MXCLST  per-cluster valid
clst_pad  in  MXCLST*MXADRB  first pad per cluster, cluster i at [i*MXADRB +: MXADRB]
clst_cnt  in  MXCLST*MXCNTB  cluster size minus 1
rom_adr0  out  MXADRB  ROM port 0 address (registered)
rom_adr1  out  MXADRB  ROM port 1 address (registered)
rom_rd0  in  MXDATB  ROM port 0 data, valid 1 clock after address
rom_rd1  in  MXDATB  ROM port 1 data
es_vld  out  1  es_lo/es_hi/es_idx valid
es_lo  out  MXDATB  min(rd0, rd1)
es_hi  out  MXDATB  max(rd0, rd1)
es_idx  out  MXCLSTB  source cluster index
busy  out  1  sequence in progress
done  out  1  one-cycle end-of-sequence pulse
start_err  out  1  one-cycle pulse: start while busy
pad_err  out  1  sticky: a valid cluster had pad >= ROMLENGTH

Behaviour:
- Reset (reset_n=0 at a clock edge): every output goes to 0, FSM to IDLE, pending mask and pipeline valids cleared. Reset mid-sequence aborts it: no es_vld or done after release.
- FSM states:
  - IDLE: on start, latch pad/cnt/vpf into pending mask -> SCAN.
  - SCAN: priority-encode lowest pending index, clear its bit. When mask is empty after the pick -> DRAIN.
  - DRAIN: wait for 2-stage pipeline to empty -> IDLE.
- Timing: start sampled in cycle 0; N = number of valid in-range clusters.
  - rom_adr0/1 for the k-th cluster (ascending index) in cycle k, k=1..N.
  - ROM data in cycle k+1; es_vld with that cluster's data in cycle k+2, one cluster per clock, no gaps.
  - done asserted in cycle N+2, coincident with the last es_vld.
  - N=0: done in cycle 1, no es_vld.
- busy is high from cycle 1 through the done cycle inclusive. start is accepted only when busy=0; the done cycle counts as busy.
- start while busy: ignored, sequence undisturbed, start_err pulses in the next cycle.
- Address arithmetic: adr0 = pad; adr1 = min(pad + cnt, ROMLENGTH-1), with the sum computed at MXADRB+1 bits, no wrap.
- Clusters with pad >= ROMLENGTH are removed from the pending mask at latch: no address cycle, no es_vld, pad_err set (cleared only by reset).
- es_lo/es_hi are ordered by an unsigned compare, so pad orientation (ME1a/ME1b) is irrelevant downstream. Equal values give es_lo = es_hi.
- es_lo/es_hi/es_idx hold their last value when es_vld=0. rom_adr holds its last value outside SCAN.
- es_idx is the original cluster index, not the sequence position.

Test Plan:
- Bench ROM rom[p]=2p+1; cluster 0 pad 10 cnt 3, start cycle 0 -> adr0=10/adr1=13 cycle 1; es_vld cycle 3 with es_lo=21, es_hi=27, es_idx=0; done cycle 3; busy cycles 1-3.
- All 8 valid, pad=20i, cnt=i -> es_vld cycles 3..10, es_idx 0..7 in order; es_lo=40i+1, es_hi=42i+1; done cycle 10.
- vpf=8'b1010_0000, pad 190 cnt 5 on index 5 -> adr1=191 (clamped); es_idx 5 then 7; done cycle 4.
- Reversed ROM rom[p]=800-2p; pad 100 cnt 2 -> es_lo=596, es_hi=600; vpf=0 start -> done cycle 1, no es_vld.
- Index 2 pad 200, index 3 pad 5 -> index 2 skipped, pad_err=1 stays; only es_idx 3 output in cycle 3; done cycle 3.
- start again in cycle 2 of an active sequence -> start_err pulse cycle 3, first sequence unaffected. reset_n=0 in cycle 2 of a 4-cluster sequence -> all outputs 0 next cycle, no es_vld/done after release; new start then runs normally.

Source files
------------

// File: rtl/gem_cluster_es_lookup.sv
// Sequences latched GEM pad clusters through the dual-port pad->eighth-strip ROM and emits ordered es ranges.
// Latency: first ROM address 1 clk after start, es_vld 2 clks after each address; one cluster per clock.
// Backpressure: none; the sink must accept every es_vld; a start while busy is dropped and flagged.
module gem_cluster_es_lookup #(
  parameter int MXCLST    = 8,
  parameter int MXCLSTB   = 3,
  parameter int MXADRB    = 8,
  parameter int MXDATB    = 10,
  parameter int MXCNTB    = 3,
  parameter int ROMLENGTH = 192
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [MXCLST-1:0]        clst_vpf,
  input  logic [MXCLST*MXADRB-1:0] clst_pad,
  input  logic [MXCLST*MXCNTB-1:0] clst_cnt,
  output logic [MXADRB-1:0]        rom_adr0,
  output logic [MXADRB-1:0]        rom_adr1,
  input  logic [MXDATB-1:0]        rom_rd0,
  input  logic [MXDATB-1:0]        rom_rd1,
  output logic                     es_vld,
  output logic [MXDATB-1:0]        es_lo,
  output logic [MXDATB-1:0]        es_hi,
  output logic [MXCLSTB-1:0]       es_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     start_err,
  output logic                     pad_err
);

  localparam logic [MXADRB:0] ROMLEN_W = (MXADRB+1)'(ROMLENGTH);
  localparam logic [MXADRB:0] ROMMAX_W = (MXADRB+1)'(ROMLENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [MXCLST-1:0]          pend_q, pend_d;
  logic [MXCLST*MXADRB-1:0]   pad_q, pad_d;
  logic [MXCLST*MXCNTB-1:0]   cnt_q, cnt_d;
  logic [MXADRB-1:0]          adr0_q, adr0_d;
  logic [MXADRB-1:0]          adr1_q, adr1_d;
  logic                       s1_vld_q, s1_vld_d;
  logic [MXCLSTB-1:0]         idx1_q, idx1_d;
  logic                       s2_vld_q, s2_vld_d;
  logic [MXCLSTB-1:0]         idx2_q, idx2_d;
  logic                       es_vld_q, es_vld_d;
  logic [MXDATB-1:0]          es_lo_q, es_lo_d;
  logic [MXDATB-1:0]          es_hi_q, es_hi_d;
  logic [MXCLSTB-1:0]         es_idx_q, es_idx_d;
  logic                       done_q, done_d;
  logic                       start_err_q, start_err_d;
  logic                       pad_err_q, pad_err_d;

  logic [MXCLST-1:0]          in_range;
  logic                       busy_w;
  logic                       accept;
  logic [MXCLST-1:0]          src_mask;
  logic [MXCLST*MXADRB-1:0]   src_pad;
  logic [MXCLST*MXCNTB-1:0]   src_cnt;
  logic [MXCLSTB-1:0]         pick_idx;
  logic                       pick_any;
  logic [MXCLST-1:0]          rest_mask;
  logic [MXADRB-1:0]          pick_pad;
  logic [MXCNTB-1:0]          pick_cnt;
  logic [MXADRB:0]            pick_sum;
  logic [MXADRB-1:0]          pick_adr1;

  // Flag which incoming clusters address a real ROM row; out-of-range ones never enter the mask.
  always_comb begin
    in_range = '0;
    for (int i = 0; i < MXCLST; i++) begin
      in_range[i] = ({1'b0, clst_pad[i*MXADRB +: MXADRB]} < ROMLEN_W);
    end
  end

  // Pick source: live inputs on the start cycle so the first address lands in cycle 1, latched copy after.
  always_comb begin
    busy_w   = (state_q != IDLE) || done_q;
    accept   = start && !busy_w;
    src_mask = (state_q == IDLE) ? (clst_vpf & in_range) : pend_q;
    src_pad  = (state_q == IDLE) ? clst_pad : pad_q;
    src_cnt  = (state_q == IDLE) ? clst_cnt : cnt_q;
  end

  // Lowest-index-first priority encoder and the mask left after removing the pick.
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    for (int i = MXCLST - 1; i >= 0; i--) begin
      if (src_mask[i]) begin
        pick_idx = MXCLSTB'(i);
        pick_any = 1'b1;
      end
    end
    rest_mask           = src_mask;
    rest_mask[pick_idx] = 1'b0;
  end

  // Port 1 address is the last pad of the cluster, widened so the sum cannot wrap, clamped to the ROM end.
  always_comb begin
    pick_pad  = src_pad[pick_idx*MXADRB +: MXADRB];
    pick_cnt  = src_cnt[pick_idx*MXCNTB +: MXCNTB];
    pick_sum  = {1'b0, pick_pad} + {{(MXADRB+1-MXCNTB){1'b0}}, pick_cnt};
    pick_adr1 = (pick_sum > ROMMAX_W) ? ROMMAX_W[MXADRB-1:0] : pick_sum[MXADRB-1:0];
  end

  // Sequencer: latch on accepted start, issue one cluster per clock, then wait for the pipeline to drain.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pad_d     = pad_q;
    cnt_d     = cnt_q;
    adr0_d    = adr0_q;
    adr1_d    = adr1_q;
    s1_vld_d  = 1'b0;
    idx1_d    = idx1_q;
    done_d    = 1'b0;
    pad_err_d = pad_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pad_d     = clst_pad;
          cnt_d     = clst_cnt;
          pad_err_d = pad_err_q | (|(clst_vpf & ~in_range));
          if (pick_any) begin
            adr0_d   = pick_pad;
            adr1_d   = pick_adr1;
            s1_vld_d = 1'b1;
            idx1_d   = pick_idx;
            pend_d   = rest_mask;
            state_d  = (rest_mask == '0) ? DRAIN : SCAN;
          end else begin
            // Nothing to look up: finish immediately, busy covers only the done cycle.
            pend_d = '0;
            done_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (pick_any) begin
          adr0_d   = pick_pad;
          adr1_d   = pick_adr1;
          s1_vld_d = 1'b1;
          idx1_d   = pick_idx;
          pend_d   = rest_mask;
          if (rest_mask == '0) begin
            state_d = DRAIN;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Last address has left stage 1; its ROM data is in stage 2, so done lines up with its es_vld.
        if (!s1_vld_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture ROM data and order it; outputs hold between valid cycles.
  always_comb begin
    s2_vld_d    = s1_vld_q;
    idx2_d      = idx1_q;
    es_vld_d    = s2_vld_q;
    es_lo_d     = es_lo_q;
    es_hi_d     = es_hi_q;
    es_idx_d    = es_idx_q;
    start_err_d = start && busy_w;
    if (s2_vld_q) begin
      es_lo_d  = (rom_rd0 <= rom_rd1) ? rom_rd0 : rom_rd1;
      es_hi_d  = (rom_rd0 <= rom_rd1) ? rom_rd1 : rom_rd0;
      es_idx_d = idx2_q;
    end
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      pad_q       <= '0;
      cnt_q       <= '0;
      adr0_q      <= '0;
      adr1_q      <= '0;
      s1_vld_q    <= 1'b0;
      idx1_q      <= '0;
      s2_vld_q    <= 1'b0;
      idx2_q      <= '0;
      es_vld_q    <= 1'b0;
      es_lo_q     <= '0;
      es_hi_q     <= '0;
      es_idx_q    <= '0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      pad_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pad_q       <= pad_d;
      cnt_q       <= cnt_d;
      adr0_q      <= adr0_d;
      adr1_q      <= adr1_d;
      s1_vld_q    <= s1_vld_d;
      idx1_q      <= idx1_d;
      s2_vld_q    <= s2_vld_d;
      idx2_q      <= idx2_d;
      es_vld_q    <= es_vld_d;
      es_lo_q     <= es_lo_d;
      es_hi_q     <= es_hi_d;
      es_idx_q    <= es_idx_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      pad_err_q   <= pad_err_d;
    end
  end

  assign rom_adr0  = adr0_q;
  assign rom_adr1  = adr1_q;
  assign es_vld    = es_vld_q;
  assign es_lo     = es_lo_q;
  assign es_hi     = es_hi_q;
  assign es_idx    = es_idx_q;
  assign busy      = busy_w;
  assign done      = done_q;
  assign start_err = start_err_q;
  assign pad_err   = pad_err_q;

endmodule

// File: tb/tb_gem_cluster_es_lookup.sv
// Bench for gem_cluster_es_lookup: behavioural dual-port ROM with 1-clock latency, scoreboard of expected es outputs.
// Expected (es_lo, es_hi, es_idx, cycle) and done cycles are queued at start and popped as the DUT emits them.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_gem_cluster_es_lookup;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  clst_vpf;
  logic [63:0] clst_pad;
  logic [23:0] clst_cnt;
  logic [7:0]  rom_adr0, rom_adr1;
  logic [9:0]  rom_rd0, rom_rd1;
  logic        es_vld;
  logic [9:0]  es_lo, es_hi;
  logic [2:0]  es_idx;
  logic        busy, done, start_err, pad_err;

  always #5 clock = ~clock;

  gem_cluster_es_lookup dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .clst_vpf(clst_vpf), .clst_pad(clst_pad), .clst_cnt(clst_cnt),
    .rom_adr0(rom_adr0), .rom_adr1(rom_adr1), .rom_rd0(rom_rd0), .rom_rd1(rom_rd1),
    .es_vld(es_vld), .es_lo(es_lo), .es_hi(es_hi), .es_idx(es_idx),
    .busy(busy), .done(done), .start_err(start_err), .pad_err(pad_err)
  );

  typedef struct {
    logic [9:0] lo;
    logic [9:0] hi;
    logic [2:0] idx;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rom_rev = 1'b0;
  exp_t mon_e;
  int   mon_d;

  function automatic logic [9:0] rom_val(input logic [7:0] p);
    if (rom_rev) return 10'(800 - 2 * int'(p));
    return 10'(2 * int'(p) + 1);
  endfunction

  always @(posedge clock) begin
    cyc     <= cyc + 1;
    rom_rd0 <= rom_val(rom_adr0);
    rom_rd1 <= rom_val(rom_adr1);
  end

  // Scoreboard: every es_vld and done must match the head of its expectation queue.
  always @(negedge clock) begin
    if (es_vld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL es_unexpected: es_vld=1 idx=%0d lo=%0d hi=%0d at cycle %0d, required no output",
                 es_idx, es_lo, es_hi, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (es_lo !== mon_e.lo || es_hi !== mon_e.hi || es_idx !== mon_e.idx || cyc !== mon_e.cyc) begin
          errors++;
          $display("FAIL es_data: got lo=%0d hi=%0d idx=%0d cyc=%0d, required lo=%0d hi=%0d idx=%0d cyc=%0d",
                   es_lo, es_hi, es_idx, cyc, mon_e.lo, mon_e.hi, mon_e.idx, mon_e.cyc);
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_d = done_q.pop_front();
        if (cyc !== mon_d) begin
          errors++;
          $display("FAIL done_cycle: got cycle %0d, required %0d", cyc, mon_d);
        end
      end
    end
  end

  // Drive a start in the current cycle (cycle 0), queue expectations, return in cycle 1.
  task automatic drive_start(input logic [7:0] vpf, input logic [63:0] pad, input logic [23:0] cnt);
    int n;
    int t0;
    logic [7:0] p, a1;
    logic [8:0] s;
    logic [9:0] r0, r1;
    exp_t e;
    n  = 0;
    t0 = cyc;
    clst_vpf = vpf;
    clst_pad = pad;
    clst_cnt = cnt;
    start    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p = pad[i*8 +: 8];
      if (vpf[i] && p < 8'd192) begin
        n++;
        s  = {1'b0, p} + {6'd0, cnt[i*3 +: 3]};
        a1 = (s > 9'd191) ? 8'd191 : s[7:0];
        r0 = rom_val(p);
        r1 = rom_val(a1);
        e.lo  = (r0 < r1) ? r0 : r1;
        e.hi  = (r0 < r1) ? r1 : r0;
        e.idx = 3'(i);
        e.cyc = t0 + n + 2;
        exp_q.push_back(e);
      end
    end
    done_q.push_back((n == 0) ? t0 + 1 : t0 + n + 2);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Bounded wait for all queued outputs; leaves the bench 1 unit into the next cycle.
  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && guard < 60) begin
      @(negedge clock);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d es and %0d done outstanding, required 0", name, exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic check_all_zero(input string name);
    logic [55:0] v;
    v = {es_vld, done, busy, start_err, pad_err, rom_adr0, rom_adr1, es_lo, es_hi, es_idx};
    checks++;
    if (v !== 56'd0) begin
      errors++;
      $display("FAIL %s: outputs=%h, required all 0", name, v);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset_state");
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [63:0] pads;
    pads = '0;
    pads[7:0] = 8'd10;
    drive_start(8'h01, pads, 24'd3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) begin
        checks++;
        if (rom_adr0 !== 8'd10 || rom_adr1 !== 8'd13) begin
          errors++;
          $display("FAIL single_adr: adr0=%0d adr1=%0d, required 10 13", rom_adr0, rom_adr1);
        end
      end
      checks++;
      if (busy !== (k <= 3)) begin
        errors++;
        $display("FAIL single_busy_c%0d: busy=%b, required %b", k, busy, (k <= 3));
      end
    end
    wait_idle("single");
  endtask

  task automatic test_all8();
    logic [63:0] pads;
    logic [23:0] cnts;
    for (int i = 0; i < 8; i++) begin
      pads[i*8 +: 8] = 8'(20 * i);
      cnts[i*3 +: 3] = 3'(i);
    end
    drive_start(8'hFF, pads, cnts);
    wait_idle("all8");
  endtask

  task automatic test_clamp();
    logic [63:0] pads;
    logic [23:0] cnts;
    pads = '0;
    cnts = '0;
    pads[5*8 +: 8] = 8'd190;
    cnts[5*3 +: 3] = 3'd5;
    pads[7*8 +: 8] = 8'd50;
    drive_start(8'b1010_0000, pads, cnts);
    @(negedge clock);
    checks++;
    if (rom_adr0 !== 8'd190 || rom_adr1 !== 8'd191) begin
      errors++;
      $display("FAIL clamp_adr: adr0=%0d adr1=%0d, required 190 191", rom_adr0, rom_adr1);
    end
    wait_idle("clamp");
  endtask

  task automatic test_reversed();
    logic [63:0] pads;
    rom_rev = 1'b1;
    pads = '0;
    pads[7:0] = 8'd100;
    drive_start(8'h01, pads, 24'd2);
    wait_idle("reversed");
    drive_start(8'h00, pads, 24'd2);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL empty_busy_c1: busy=%b, required 1", busy);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_busy_c2: busy=%b, required 0", busy);
    end
    wait_idle("empty");
    rom_rev = 1'b0;
  endtask

  task automatic test_pad_err();
    logic [63:0] pads;
    logic [23:0] cnts;
    pads = '0;
    cnts = '0;
    pads[2*8 +: 8] = 8'd200;
    pads[3*8 +: 8] = 8'd5;
    cnts[3*3 +: 3] = 3'd1;
    drive_start(8'b0000_1100, pads, cnts);
    @(negedge clock);
    checks++;
    if (pad_err !== 1'b1 || rom_adr0 !== 8'd5) begin
      errors++;
      $display("FAIL pad_err_set: pad_err=%b adr0=%0d, required 1 5", pad_err, rom_adr0);
    end
    wait_idle("pad_err");
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (pad_err !== 1'b1) begin
      errors++;
      $display("FAIL pad_err_sticky: pad_err=%b, required 1", pad_err);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_start_err();
    logic [63:0] pads;
    for (int i = 0; i < 8; i++) pads[i*8 +: 8] = 8'(30 + i);
    drive_start(8'b0100_0011, pads, 24'o01234567);
    @(negedge clock);
    checks++;
    if (start_err !== 1'b0) begin
      errors++;
      $display("FAIL start_err_c1: start_err=%b, required 0", start_err);
    end
    @(posedge clock); #1;
    clst_vpf = 8'hFF;
    clst_pad = '0;
    start    = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
    @(negedge clock);
    checks++;
    if (start_err !== 1'b1) begin
      errors++;
      $display("FAIL start_err_c3: start_err=%b, required 1", start_err);
    end
    @(negedge clock);
    checks++;
    if (start_err !== 1'b0) begin
      errors++;
      $display("FAIL start_err_c4: start_err=%b, required 0", start_err);
    end
    wait_idle("start_err");
  endtask

  task automatic test_reset_mid();
    logic [63:0] pads;
    for (int i = 0; i < 8; i++) pads[i*8 +: 8] = 8'(11 * i);
    drive_start(8'h0F, pads, 24'd0);
    @(posedge clock); #1;
    reset_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_all_zero("reset_mid_state");
    repeat (10) @(negedge clock);
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] pads;
    logic [23:0] cnts;
    for (int i = 0; i < 8; i++) begin
      pads[i*8 +: 8] = 8'(7 + 23 * i);
      cnts[i*3 +: 3] = 3'(7 - i);
    end
    drive_start(8'b1001_0110, pads, cnts);
    wait_idle("b2b_first");
    drive_start(8'b0110_1001, pads, cnts);
    wait_idle("b2b_second");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    clst_vpf = '0;
    clst_pad = '0;
    clst_cnt = '0;
    @(posedge clock); #1;
    test_reset();
    test_single();
    test_all8();
    test_clamp();
    test_reversed();
    test_pad_err();
    test_start_err();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
